// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: cause codes,
// sequencer state encoding and the mtvec vectored-mode value.
package trap_pkg;

    localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;
    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;

    localparam logic [3:0] IRQ_MEI = 4'd11;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRAP   = 2'd1;
    localparam logic [1:0] ST_VECTOR = 2'd2;
    localparam logic [1:0] ST_MRET   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        TRAP   = ST_TRAP,
        VECTOR = ST_VECTOR,
        MRET   = ST_MRET
    } trap_state_t;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap priority encoder: picks the highest-priority exception,
// or failing that the highest-priority already-masked interrupt.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic       ebreak,
    input  logic       instr_misalign,
    input  logic       illegal,
    input  logic       ecall,
    input  logic       ld_misalign,
    input  logic       st_misalign,
    input  logic       mei,
    input  logic       msi,
    input  logic       mti,
    output logic       valid,
    output logic       is_irq,
    output logic [3:0] cause
);

    always_comb begin
        valid  = 1'b1;
        is_irq = 1'b0;
        cause  = 4'd0;
        if (ebreak)              cause = CAUSE_EBREAK;
        else if (instr_misalign) cause = CAUSE_IMISALIGN;
        else if (illegal)        cause = CAUSE_ILLEGAL;
        else if (ecall)          cause = CAUSE_ECALL_M;
        else if (ld_misalign)    cause = CAUSE_LMISALIGN;
        else if (st_misalign)    cause = CAUSE_SMISALIGN;
        else if (mei) begin
            is_irq = 1'b1;
            cause  = IRQ_MEI;
        end else if (msi) begin
            is_irq = 1'b1;
            cause  = IRQ_MSI;
        end else if (mti) begin
            is_irq = 1'b1;
            cause  = IRQ_MTI;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions/interrupts at the commit boundary,
// strobes mcause/mepc, flushes and redirects fetch to mtvec, and sequences mret.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic            clock,
    input  logic            rst_n_in,
    input  logic            instr_valid_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            ebreak_in,
    input  logic            instr_misalign_in,
    input  logic            illegal_in,
    input  logic            ecall_in,
    input  logic            ld_misalign_in,
    input  logic            st_misalign_in,
    input  logic            meip_in,
    input  logic            msip_in,
    input  logic            mtip_in,
    input  logic [XLEN-1:0] mie_in,
    input  logic            mstatus_mie_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    input  logic            mret_in,
    output logic            set_cause_out,
    output logic [3:0]      cause_out,
    output logic            i_or_e_out,
    output logic            set_epc_out,
    output logic [XLEN-1:0] epc_out,
    output logic            mie_clear_out,
    output logic            mie_restore_out,
    output logic            flush_out,
    output logic            redirect_out,
    output logic [XLEN-1:0] pc_target_out,
    output logic            busy_out
);

    trap_state_t     state;
    logic            req_valid;
    logic            req_is_irq;
    logic [3:0]      req_cause;
    logic            use_vectored;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_target;
    logic            unused_mie;

    trap_prio_enc u_prio (
        .ebreak         (ebreak_in),
        .instr_misalign (instr_misalign_in),
        .illegal        (illegal_in),
        .ecall          (ecall_in),
        .ld_misalign    (ld_misalign_in),
        .st_misalign    (st_misalign_in),
        .mei            (meip_in & mie_in[11] & mstatus_mie_in),
        .msi            (msip_in & mie_in[3]  & mstatus_mie_in),
        .mti            (mtip_in & mie_in[7]  & mstatus_mie_in),
        .valid          (req_valid),
        .is_irq         (req_is_irq),
        .cause          (req_cause)
    );

    assign unused_mie = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:4], mie_in[2:0]};

    // Vectoring applies only to interrupts; exceptions always land on the base.
    assign vec_base     = {mtvec_in[XLEN-1:2], 2'b00};
    assign use_vectored = VECTORED_EN && (mtvec_in[1:0] == MTVEC_MODE_VECTORED) && i_or_e_out;
    assign vec_target   = use_vectored ? vec_base + {{(XLEN-6){1'b0}}, cause_out, 2'b00} : vec_base;

    always_ff @(posedge clock or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            set_cause_out   <= 1'b0;
            cause_out       <= 4'd0;
            i_or_e_out      <= 1'b0;
            set_epc_out     <= 1'b0;
            epc_out         <= '0;
            mie_clear_out   <= 1'b0;
            mie_restore_out <= 1'b0;
            flush_out       <= 1'b0;
            redirect_out    <= 1'b0;
            pc_target_out   <= '0;
            busy_out        <= 1'b0;
        end else begin
            set_cause_out   <= 1'b0;
            set_epc_out     <= 1'b0;
            mie_clear_out   <= 1'b0;
            mie_restore_out <= 1'b0;
            flush_out       <= 1'b0;
            redirect_out    <= 1'b0;
            busy_out        <= 1'b0;
            case (state)
                IDLE: begin
                    // An exception beats mret, but mret beats a pending interrupt.
                    if (instr_valid_in) begin
                        if (req_valid && !(req_is_irq && mret_in)) begin
                            state         <= TRAP;
                            cause_out     <= req_cause;
                            i_or_e_out    <= req_is_irq;
                            epc_out       <= pc_in;
                            set_cause_out <= 1'b1;
                            set_epc_out   <= 1'b1;
                            mie_clear_out <= 1'b1;
                            flush_out     <= 1'b1;
                            busy_out      <= 1'b1;
                        end else if (mret_in) begin
                            state           <= MRET;
                            pc_target_out   <= mepc_in;
                            mie_restore_out <= 1'b1;
                            flush_out       <= 1'b1;
                            redirect_out    <= 1'b1;
                            busy_out        <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    state         <= VECTOR;
                    pc_target_out <= vec_target;
                    redirect_out  <= 1'b1;
                    busy_out      <= 1'b1;
                end
                VECTOR:  state <= IDLE;
                MRET:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a directed vector table, hand-written busy/reset
// sequences and randomized requests checked against a priority-list reference model.
module tb_trap_ctrl;

    typedef struct {
        logic        valid;
        logic [5:0]  exc;
        logic [2:0]  irq;
        logic [31:0] mie;
        logic        mstatus_mie;
        logic        mret;
        logic [31:0] pc;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        int          kind;
        logic [3:0]  cause;
        logic        is_irq;
        logic [31:0] tgt_v;
        logic [31:0] tgt_d;
    } vec_t;

    logic        clock;
    logic        rst_n_in;
    logic        instr_valid_in;
    logic [31:0] pc_in;
    logic        ebreak_in, instr_misalign_in, illegal_in, ecall_in, ld_misalign_in, st_misalign_in;
    logic        meip_in, msip_in, mtip_in;
    logic [31:0] mie_in;
    logic        mstatus_mie_in;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        mret_in;

    logic        set_cause_out, i_or_e_out, set_epc_out, mie_clear_out, mie_restore_out;
    logic        flush_out, redirect_out, busy_out;
    logic [3:0]  cause_out;
    logic [31:0] epc_out, pc_target_out;

    logic        d_set_cause, d_i_or_e, d_set_epc, d_mie_clear, d_mie_restore;
    logic        d_flush, d_redirect, d_busy;
    logic [3:0]  d_cause;
    logic [31:0] d_epc, d_target;

    int          checks;
    int          errors;
    logic [3:0]  last_cause;
    logic        last_irq;
    logic [31:0] last_epc;
    vec_t        tbl[15];

    trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b1)) dut_v (
        .clock(clock), .rst_n_in(rst_n_in), .instr_valid_in(instr_valid_in), .pc_in(pc_in),
        .ebreak_in(ebreak_in), .instr_misalign_in(instr_misalign_in), .illegal_in(illegal_in),
        .ecall_in(ecall_in), .ld_misalign_in(ld_misalign_in), .st_misalign_in(st_misalign_in),
        .meip_in(meip_in), .msip_in(msip_in), .mtip_in(mtip_in), .mie_in(mie_in),
        .mstatus_mie_in(mstatus_mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in), .mret_in(mret_in),
        .set_cause_out(set_cause_out), .cause_out(cause_out), .i_or_e_out(i_or_e_out),
        .set_epc_out(set_epc_out), .epc_out(epc_out), .mie_clear_out(mie_clear_out),
        .mie_restore_out(mie_restore_out), .flush_out(flush_out), .redirect_out(redirect_out),
        .pc_target_out(pc_target_out), .busy_out(busy_out)
    );

    trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b0)) dut_d (
        .clock(clock), .rst_n_in(rst_n_in), .instr_valid_in(instr_valid_in), .pc_in(pc_in),
        .ebreak_in(ebreak_in), .instr_misalign_in(instr_misalign_in), .illegal_in(illegal_in),
        .ecall_in(ecall_in), .ld_misalign_in(ld_misalign_in), .st_misalign_in(st_misalign_in),
        .meip_in(meip_in), .msip_in(msip_in), .mtip_in(mtip_in), .mie_in(mie_in),
        .mstatus_mie_in(mstatus_mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in), .mret_in(mret_in),
        .set_cause_out(d_set_cause), .cause_out(d_cause), .i_or_e_out(d_i_or_e),
        .set_epc_out(d_set_epc), .epc_out(d_epc), .mie_clear_out(d_mie_clear),
        .mie_restore_out(d_mie_restore), .flush_out(d_flush), .redirect_out(d_redirect),
        .pc_target_out(d_target), .busy_out(d_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: walk the architectural priority lists in order.
    function automatic vec_t model(input vec_t v);
        int exc_code[6] = '{3, 0, 2, 11, 4, 6};
        int irq_code[3] = '{11, 3, 7};
        logic [31:0] base;
        v.kind   = 0;
        v.cause  = 4'd0;
        v.is_irq = 1'b0;
        if (v.valid) begin
            for (int i = 0; i < 6; i++)
                if (v.exc[i] && v.kind == 0) begin
                    v.kind  = 1;
                    v.cause = 4'(exc_code[i]);
                end
            if (v.kind == 0 && v.mret) v.kind = 2;
            if (v.kind == 0 && v.mstatus_mie)
                for (int j = 0; j < 3; j++)
                    if (v.irq[j] && v.mie[irq_code[j]] && v.kind == 0) begin
                        v.kind   = 1;
                        v.cause  = 4'(irq_code[j]);
                        v.is_irq = 1'b1;
                    end
        end
        base    = v.mtvec & 32'hFFFF_FFFC;
        v.tgt_d = base;
        v.tgt_v = (v.is_irq && v.mtvec % 4 == 1) ? base + 4 * 32'(v.cause) : base;
        return v;
    endfunction

    function automatic vec_t mk(input logic valid, input logic [5:0] exc, input logic [2:0] irq,
                                input logic [31:0] mie, input logic mst, input logic mret,
                                input logic [31:0] pc, input logic [31:0] mtvec, input logic [31:0] mepc,
                                input int kind, input int cause, input logic is_irq,
                                input logic [31:0] tv, input logic [31:0] td);
        vec_t v;
        v.valid = valid; v.exc = exc; v.irq = irq; v.mie = mie; v.mstatus_mie = mst;
        v.mret = mret; v.pc = pc; v.mtvec = mtvec; v.mepc = mepc; v.kind = kind;
        v.cause = 4'(cause); v.is_irq = is_irq; v.tgt_v = tv; v.tgt_d = td;
        return v;
    endfunction

    function automatic vec_t randVec();
        vec_t v;
        v.valid = ($urandom_range(9) != 0);
        for (int i = 0; i < 6; i++) v.exc[i] = ($urandom_range(7) == 0);
        for (int j = 0; j < 3; j++) v.irq[j] = ($urandom_range(2) == 0);
        v.mie         = $urandom;
        v.mstatus_mie = 1'($urandom_range(1));
        v.mret        = ($urandom_range(5) == 0);
        v.pc          = $urandom & 32'hFFFF_FFFC;
        v.mtvec       = $urandom;
        v.mepc        = $urandom & 32'hFFFF_FFFC;
        return model(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearReq();
        instr_valid_in = 1'b0;
        {ebreak_in, instr_misalign_in, illegal_in, ecall_in, ld_misalign_in, st_misalign_in} = 6'b0;
        {meip_in, msip_in, mtip_in} = 3'b0;
        mret_in = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        instr_valid_in = v.valid;
        {st_misalign_in, ld_misalign_in, ecall_in, illegal_in, instr_misalign_in, ebreak_in} = v.exc;
        {mtip_in, msip_in, meip_in} = v.irq;
        mie_in = v.mie; mstatus_mie_in = v.mstatus_mie; mret_in = v.mret;
        pc_in = v.pc; mtvec_in = v.mtvec; mepc_in = v.mepc;
    endtask

    // Present one request for a single boundary cycle; CSR inputs stay put afterwards.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        drive(v);
        @(negedge clock);
        clearReq();
    endtask

    task automatic checkOutput(input vec_t v);
        if (v.kind == 1) begin
            check("trap.set_cause", 32'(set_cause_out), 1);
            check("trap.set_epc", 32'(set_epc_out), 1);
            check("trap.mie_clear", 32'(mie_clear_out), 1);
            check("trap.flush", 32'(flush_out), 1);
            check("trap.redirect_early", 32'(redirect_out), 0);
            check("trap.busy", 32'(busy_out), 1);
            check("trap.cause", 32'(cause_out), 32'(v.cause));
            check("trap.i_or_e", 32'(i_or_e_out), 32'(v.is_irq));
            check("trap.epc", epc_out, v.pc);
            check("trap.d_set_cause", 32'(d_set_cause), 1);
            last_cause = v.cause; last_irq = v.is_irq; last_epc = v.pc;
            @(negedge clock);
            check("vector.set_cause", 32'(set_cause_out), 0);
            check("vector.flush", 32'(flush_out), 0);
            check("vector.redirect", 32'(redirect_out), 1);
            check("vector.busy", 32'(busy_out), 1);
            check("vector.target", pc_target_out, v.tgt_v);
            check("vector.d_target", d_target, v.tgt_d);
            check("vector.cause_hold", 32'(cause_out), 32'(v.cause));
            @(negedge clock);
            check("post.busy", 32'(busy_out), 0);
            check("post.redirect", 32'(redirect_out), 0);
        end else if (v.kind == 2) begin
            check("mret.restore", 32'(mie_restore_out), 1);
            check("mret.flush", 32'(flush_out), 1);
            check("mret.redirect", 32'(redirect_out), 1);
            check("mret.target", pc_target_out, v.mepc);
            check("mret.d_target", d_target, v.mepc);
            check("mret.set_cause", 32'(set_cause_out), 0);
            check("mret.mie_clear", 32'(mie_clear_out), 0);
            check("mret.busy", 32'(busy_out), 1);
            check("mret.cause_hold", 32'(cause_out), 32'(last_cause));
            @(negedge clock);
            check("mret_post.busy", 32'(busy_out), 0);
            check("mret_post.restore", 32'(mie_restore_out), 0);
            check("mret_post.redirect", 32'(redirect_out), 0);
        end else begin
            check("none.set_cause", 32'(set_cause_out), 0);
            check("none.set_epc", 32'(set_epc_out), 0);
            check("none.flush", 32'(flush_out), 0);
            check("none.redirect", 32'(redirect_out), 0);
            check("none.busy", 32'(busy_out), 0);
            check("none.cause_hold", 32'(cause_out), 32'(last_cause));
            check("none.i_or_e_hold", 32'(i_or_e_out), 32'(last_irq));
            check("none.epc_hold", epc_out, last_epc);
        end
    endtask

    initial begin
        vec_t v;
        checks = 0; errors = 0;
        last_cause = 4'd0; last_irq = 1'b0; last_epc = 32'd0;
        rst_n_in = 1'b0;
        clearReq();
        mie_in = '0; mstatus_mie_in = 1'b0; pc_in = '0; mtvec_in = '0; mepc_in = '0;

        tbl[0]  = mk(1, 6'b000100, 3'b000, 32'h0,   0, 0, 32'h100, 32'h200, 32'h0,   1, 2,  0, 32'h200, 32'h200);
        tbl[1]  = mk(1, 6'b000000, 3'b100, 32'h80,  1, 0, 32'h300, 32'h401, 32'h0,   1, 7,  1, 32'h41C, 32'h400);
        tbl[2]  = mk(1, 6'b000101, 3'b001, 32'h800, 1, 0, 32'h304, 32'h401, 32'h0,   1, 3,  0, 32'h400, 32'h400);
        tbl[3]  = mk(1, 6'b000000, 3'b111, 32'h888, 1, 0, 32'h308, 32'h401, 32'h0,   1, 11, 1, 32'h42C, 32'h400);
        tbl[4]  = mk(1, 6'b000000, 3'b000, 32'h0,   0, 1, 32'h30C, 32'h401, 32'hABC, 2, 0,  0, 32'hABC, 32'hABC);
        tbl[5]  = mk(1, 6'b000000, 3'b100, 32'h80,  1, 1, 32'h310, 32'h401, 32'hABC, 2, 0,  0, 32'hABC, 32'hABC);
        tbl[6]  = mk(1, 6'b000000, 3'b100, 32'h80,  1, 0, 32'h314, 32'h401, 32'h0,   1, 7,  1, 32'h41C, 32'h400);
        tbl[7]  = mk(1, 6'b000000, 3'b001, 32'h800, 0, 0, 32'h318, 32'h401, 32'h0,   0, 0,  0, 32'h0,   32'h0);
        tbl[8]  = mk(0, 6'b000100, 3'b000, 32'h0,   0, 0, 32'h31C, 32'h401, 32'h0,   0, 0,  0, 32'h0,   32'h0);
        tbl[9]  = mk(1, 6'b011000, 3'b000, 32'h0,   0, 0, 32'h320, 32'h1000, 32'h0,  1, 11, 0, 32'h1000, 32'h1000);
        tbl[10] = mk(1, 6'b100000, 3'b000, 32'h0,   0, 1, 32'h324, 32'h2000, 32'hABC, 1, 6, 0, 32'h2000, 32'h2000);
        tbl[11] = mk(1, 6'b000000, 3'b110, 32'h008, 1, 0, 32'h328, 32'h101, 32'h0,   1, 3,  1, 32'h10C, 32'h100);
        tbl[12] = mk(1, 6'b000000, 3'b100, 32'h800, 1, 0, 32'h32C, 32'h101, 32'h0,   0, 0,  0, 32'h0,   32'h0);
        tbl[13] = mk(1, 6'b010010, 3'b000, 32'h0,   0, 0, 32'h330, 32'hFFFF_FFFD, 32'h0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        tbl[14] = mk(1, 6'b000000, 3'b001, 32'h800, 1, 0, 32'h334, 32'hFFFF_FFF1, 32'h0, 1, 11, 1, 32'h1C, 32'hFFFF_FFF0);

        repeat (2) @(negedge clock);
        check("reset.set_cause", 32'(set_cause_out), 0);
        check("reset.cause", 32'(cause_out), 0);
        check("reset.epc", epc_out, 0);
        check("reset.target", pc_target_out, 0);
        check("reset.busy", 32'(busy_out), 0);
        check("reset.redirect", 32'(redirect_out), 0);
        check("reset.flush", 32'(flush_out), 0);
        rst_n_in = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end

        // A second request presented during TRAP and VECTOR must be dropped.
        @(negedge clock);
        v = model(mk(1, 6'b001000, 3'b000, 32'h0, 0, 0, 32'h700, 32'h800, 32'h0, 0, 0, 0, 32'h0, 32'h0));
        drive(v);
        @(negedge clock);
        check("busy_drop.set_cause", 32'(set_cause_out), 1);
        check("busy_drop.cause", 32'(cause_out), 11);
        illegal_in = 1'b1; ecall_in = 1'b0; pc_in = 32'h900;
        @(negedge clock);
        check("busy_drop.redirect", 32'(redirect_out), 1);
        check("busy_drop.target", pc_target_out, 32'h800);
        @(negedge clock);
        clearReq();
        check("busy_drop.idle_busy", 32'(busy_out), 0);
        check("busy_drop.idle_strobe", 32'(set_cause_out), 0);
        @(negedge clock);
        check("busy_drop.no_strobe", 32'(set_cause_out), 0);
        check("busy_drop.cause_hold", 32'(cause_out), 11);
        check("busy_drop.epc_hold", epc_out, 32'h700);

        // Asynchronous reset while in TRAP: everything clears at once and no redirect follows.
        @(negedge clock);
        v = model(mk(1, 6'b000100, 3'b000, 32'h0, 0, 0, 32'h500, 32'h600, 32'h0, 0, 0, 0, 32'h0, 32'h0));
        drive(v);
        @(negedge clock);
        clearReq();
        check("midreset.in_trap", 32'(set_cause_out), 1);
        #2 rst_n_in = 1'b0;
        #1;
        check("midreset.set_cause", 32'(set_cause_out), 0);
        check("midreset.set_epc", 32'(set_epc_out), 0);
        check("midreset.flush", 32'(flush_out), 0);
        check("midreset.mie_clear", 32'(mie_clear_out), 0);
        check("midreset.busy", 32'(busy_out), 0);
        check("midreset.cause", 32'(cause_out), 0);
        check("midreset.epc", epc_out, 0);
        @(negedge clock);
        rst_n_in = 1'b1;
        last_cause = 4'd0; last_irq = 1'b0; last_epc = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("midreset.no_redirect", 32'(redirect_out), 0);
            check("midreset.idle", 32'(busy_out), 0);
        end

        for (int n = 0; n < 300; n++) begin
            v = randVec();
            applyStimulus(v);
            checkOutput(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
